// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int RR_MAX_REQ = 32;

    // Index of the first set request after 'last', wrapping at num_req; -1 when none is set.
    function automatic int rr_next(input logic [RR_MAX_REQ-1:0] req,
                                   input int num_req,
                                   input int last);
        int idx;
        rr_next = -1;
        for (int k = num_req; k >= 1; k--) begin
            idx = (last + k) % num_req;
            if (req[idx]) begin
                rr_next = idx;
            end
        end
    endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Round-robin winner select: rotate requests so last+1 sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [$clog2(NUM_REQ)-1:0] win_idx,
    output logic                       win_valid
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]     shift;
    logic [IDX_W-1:0]     off;
    logic [IDX_W:0]       sum_w;

    assign req_dbl = {req, req};
    assign shift   = (last == LAST_IDX) ? '0 : last + 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign req_rot[gi] = req_dbl[32'(shift) + gi];
        end
    endgenerate

    always_comb begin
        off       = '0;
        win_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                off       = IDX_W'(k);
                win_valid = 1'b1;
            end
        end
    end

    always_comb begin
        sum_w = {1'b0, shift} + {1'b0, off};
        if (sum_w >= NUM_REQ_W) begin
            sum_w = sum_w - NUM_REQ_W;
        end
        win_idx = sum_w[IDX_W-1:0];
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers,
// with bounded bursts per grant and combinational stall on full.
module fifo_wr_arb
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    owner
);
    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [BEAT_W-1:0] beat_q, beat_d;

    logic [IDX_W-1:0]      win_idx;
    logic                  win_valid;
    logic                  owner_req;
    logic                  beat_fire;
    logic                  release_now;
    logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req       (req),
        .last      (last_q),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    // full gates the beat combinationally so a write can never land on a full FIFO.
    assign owner_req   = req[owner_q];
    assign beat_fire   = (state_q == GRANT) && owner_req && !full;
    assign release_now = (state_q == GRANT) &&
                         (!owner_req || (beat_fire && (beat_q == LAST_BEAT)));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (win_valid && !full) begin
                    state_d = GRANT;
                    owner_d = win_idx;
                    beat_d  = '0;
                end
            end
            GRANT: begin
                if (beat_fire) begin
                    beat_d = beat_q + 1'b1;
                end
                if (release_now) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt     = '0;
        wr_en   = 1'b0;
        data_in = '0;
        if (beat_fire) begin
            wr_en        = 1'b1;
            gnt[owner_q] = 1'b1;
            data_in      = req_data_arr[owner_q];
        end
    end

    assign busy  = (state_q == GRANT);
    assign owner = owner_q;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios plus random traffic against a queue-based model.
module tb_fifo_wr_arb;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int MB    = 4;
    localparam int BOUND = N * (MB + 1);

    logic          clk = 1'b0;
    logic          rstN;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_data;
    logic          full;
    logic [N-1:0]  gnt;
    logic          wr_en;
    logic [DW-1:0] data_in;
    logic          busy;
    logic [1:0]    owner;

    logic [N-1:0]    req1;
    logic [N*DW-1:0] req_data1;
    logic            full1;
    logic [N-1:0]    gnt1;
    logic            wr_en1;
    logic [DW-1:0]   data_in1;
    logic            busy1;
    logic [1:0]      owner1;

    always #5 clk = ~clk;

    fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rstN(rstN), .req(req), .req_data(req_data), .gnt(gnt),
        .full(full), .wr_en(wr_en), .data_in(data_in), .busy(busy), .owner(owner)
    );

    fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(1)) dut1 (
        .clk(clk), .rstN(rstN), .req(req1), .req_data(req_data1), .gnt(gnt1),
        .full(full1), .wr_en(wr_en1), .data_in(data_in1), .busy(busy1), .owner(owner1)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit verbose  = 1'b1;

    // Requester-side queues: send_q is what is still offered, exp_q what must come out in order.
    logic [DW-1:0] send_q [N][$];
    logic [DW-1:0] exp_q  [N][$];
    logic [N-1:0]  gnt_seen = '0;
    int            wait_cnt [N];

    int            wr_cyc [$];
    int            wr_who [$];
    logic [DW-1:0] wr_dat [$];

    // Abstract model: is a grant open, whose, how many beats taken, who was served last.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_last  = N - 1;
    int m_cnt   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i] = (send_q[i].size() != 0);
            req_data[i*DW +: DW] = (send_q[i].size() != 0) ? send_q[i][0] : '0;
        end
    endtask

    task automatic push(input int i, input logic [DW-1:0] d);
        send_q[i].push_back(d);
        exp_q[i].push_back(d);
        drive();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (gnt_seen[i]) void'(send_q[i].pop_front());
        end
        gnt_seen = '0;
        drive();
    endtask

    task automatic clear_log();
        wr_cyc.delete();
        wr_who.delete();
        wr_dat.delete();
    endtask

    task automatic wait_writes(input int n, input int limit);
        int k;
        k = 0;
        while (wr_who.size() < n && k < limit) begin
            step();
            k++;
        end
        chk("write_timeout", 32'(wr_who.size() >= n), 32'd1);
    endtask

    task automatic drain(input int limit);
        int k;
        bit pending;
        k = 0;
        pending = 1'b1;
        while (pending && k < limit) begin
            step();
            k++;
            pending = 1'b0;
            for (int i = 0; i < N; i++) if (send_q[i].size() != 0) pending = 1'b1;
        end
        chk("drain_timeout", 32'(pending), 32'd0);
        repeat (3) step();
    endtask

    always @(negedge clk) begin
        bit fire;
        int pick;
        if (!rstN) begin
            chk("rst_wr_en", 32'(wr_en), 32'd0);
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_data_in", 32'(data_in), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_owner", 32'(owner), 32'd0);
            m_busy  = 1'b0;
            m_owner = 0;
            m_last  = N - 1;
            m_cnt   = 0;
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end else begin
            fire = m_busy && req[m_owner] && !full;
            chk("wr_en", 32'(wr_en), 32'(fire));
            chk("gnt", 32'(gnt), fire ? 32'(1 << m_owner) : 32'd0);
            chk("data_in", 32'(data_in), fire ? 32'(req_data[m_owner*DW +: DW]) : 32'd0);
            chk("busy", 32'(busy), 32'(m_busy));
            chk("owner", 32'(owner), 32'(m_owner));
            chk("no_write_on_full", 32'(wr_en && full), 32'd0);
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            chk("wr_en_is_or_gnt", 32'(wr_en), 32'(|gnt));

            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    gnt_seen[i] = 1'b1;
                    if (exp_q[i].size() == 0) begin
                        chk("unexpected_write", 32'(i), 32'hFFFF_FFFF);
                    end else begin
                        chk("data_order", 32'(data_in), 32'(exp_q[i].pop_front()));
                    end
                    if (verbose) begin
                        $display("cycle %0d: write req%0d data 0x%02h", cyc, i, data_in);
                        wr_cyc.push_back(cyc);
                        wr_who.push_back(i);
                        wr_dat.push_back(data_in);
                    end
                    wait_cnt[i] = 0;
                end else if (!req[i]) begin
                    wait_cnt[i] = 0;
                end else if (!full) begin
                    wait_cnt[i]++;
                    chk("starvation_bound", 32'(wait_cnt[i] <= BOUND), 32'd1);
                end
            end

            if (!m_busy) begin
                if (req != '0 && !full) begin
                    pick = -1;
                    for (int k = N; k >= 1; k--) if (req[(m_last + k) % N]) pick = (m_last + k) % N;
                    m_busy  = 1'b1;
                    m_owner = pick;
                    m_cnt   = 0;
                end
            end else begin
                if (fire) m_cnt++;
                if (!req[m_owner] || m_cnt == MB) begin
                    m_busy = 1'b0;
                    m_last = m_owner;
                end
            end
        end
    end

    initial begin
        int t0;
        bit exp_w;
        rstN = 1'b0;
        req = '0; req_data = '0; full = 1'b0;
        req1 = '0; req_data1 = '0; full1 = 1'b0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        #2;
        chk("init_wr_en", 32'(wr_en), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_owner", 32'(owner), 32'd0);
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        repeat (2) step();

        // MAX_BURST=1 instance with all four requesting: strict rotation with bubbles.
        req1 = '1;
        for (int i = 0; i < N; i++) req_data1[i*DW +: DW] = 8'(8'h10 + i);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_w = (k % 2 == 1);
            chk("mb1_wr_en", 32'(wr_en1), 32'(exp_w));
            chk("mb1_busy", 32'(busy1), 32'(exp_w));
            if (exp_w) begin
                chk("mb1_owner", 32'(owner1), 32'(((k - 1) / 2) % N));
                chk("mb1_data", 32'(data_in1), 32'(8'h10 + ((k - 1) / 2) % N));
                $display("cycle %0d: mb1 write owner %0d data 0x%02h", cyc, owner1, data_in1);
            end
            step();
        end
        req1 = '0;
        repeat (3) step();

        // Six beats from requester 0: burst of four, one bubble, then two.
        clear_log();
        for (int i = 0; i < 6; i++) push(0, 8'(8'hA0 + i));
        t0 = cyc;
        wait_writes(6, 40);
        chk("burst_count", 32'(wr_who.size()), 32'd6);
        if (wr_who.size() >= 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("burst_data", 32'(wr_dat[i]), 32'(8'hA0 + i));
                chk("burst_who", 32'(wr_who[i]), 32'd0);
            end
            chk("first_write_latency", 32'(wr_cyc[0] - t0), 32'd1);
            chk("burst_no_bubble", 32'(wr_cyc[3] - wr_cyc[0]), 32'd3);
            chk("one_idle_between", 32'(wr_cyc[4] - wr_cyc[3]), 32'd2);
            chk("second_grant_b2b", 32'(wr_cyc[5] - wr_cyc[4]), 32'd1);
        end
        drain(20);

        // Requester 2 stalled by full for three cycles mid-burst.
        clear_log();
        for (int i = 0; i < 4; i++) push(2, 8'(8'hC0 + i));
        wait_writes(2, 20);
        full = 1'b1;
        repeat (3) begin
            step();
            chk("stall_busy", 32'(busy), 32'd1);
        end
        full = 1'b0;
        wait_writes(4, 20);
        if (wr_who.size() >= 4) begin
            chk("stall_span", 32'(wr_cyc[3] - wr_cyc[0]), 32'd6);
            chk("stall_resume_gap", 32'(wr_cyc[2] - wr_cyc[1]), 32'd4);
            chk("stall_who", 32'(wr_who[3]), 32'd2);
        end
        drain(20);

        // Owner 1 drops its request after two beats while 3 waits.
        clear_log();
        for (int i = 0; i < 4; i++) push(1, 8'(8'hD0 + i));
        wait_writes(1, 20);
        push(3, 8'hE0);
        push(3, 8'hE1);
        wait_writes(2, 20);
        send_q[1].delete();
        exp_q[1].delete();
        drive();
        step();
        chk("model_last_after_drop", 32'(m_last), 32'd1);
        chk("idle_after_drop_busy", 32'(busy), 32'd0);
        chk("idle_after_drop_owner", 32'(owner), 32'd1);
        wait_writes(3, 20);
        if (wr_who.size() >= 3) begin
            chk("next_owner_after_drop", 32'(wr_who[2]), 32'd3);
            chk("drop_to_next_gap", 32'(wr_cyc[2] - wr_cyc[1]), 32'd3);
        end
        drain(20);

        // Asynchronous reset in the middle of a burst.
        clear_log();
        for (int i = 0; i < 8; i++) push(2, 8'(8'hB0 + i));
        push(3, 8'h3C);
        wait_writes(2, 20);
        rstN = 1'b0;
        #1;
        chk("rst_mid_wr_en", 32'(wr_en), 32'd0);
        chk("rst_mid_gnt", 32'(gnt), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        push(0, 8'h5A);
        clear_log();
        step();
        rstN = 1'b1;
        wait_writes(1, 20);
        if (wr_who.size() >= 1) begin
            chk("post_reset_first_who", 32'(wr_who[0]), 32'd0);
            chk("post_reset_first_data", 32'(wr_dat[0]), 32'h5A);
        end
        drain(60);

        // Random traffic: the monitor checks model, invariants, order and service bound.
        verbose = 1'b0;
        clear_log();
        for (int c = 0; c < 10000; c++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (send_q[i].size() == 0 && $urandom_range(0, 9) < 3) begin
                    for (int b = $urandom_range(1, 6); b > 0; b--) push(i, 8'($urandom));
                end
            end
            full = ($urandom_range(0, 3) == 0);
        end
        full = 1'b0;
        drain(200);
        for (int i = 0; i < N; i++) chk("scoreboard_empty", 32'(exp_q[i].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
